// File: rtl/regfile_ctx_ctrl.sv
// Register-file context save/restore controller: streams x1..x(NReg-1) out, or writes them back in.
// Optional REGFILE_CTX_CHECKSUM_EN appends/verifies an XOR checksum word on the streams.
module regfile_ctx_ctrl #(
    parameter int unsigned XLen      = 32,
    parameter int unsigned NReg      = 32,
    parameter int unsigned NRegWidth = $clog2(NReg)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 cmd_valid_i,
    input  logic                 cmd_op_i,
    output logic                 cmd_ready_o,

    output logic [NRegWidth-1:0] a1_o,
    input  logic [XLen-1:0]      rd1_i,
    output logic [NRegWidth-1:0] a3_o,
    output logic                 we3_o,
    output logic [XLen-1:0]      wd3_o,

    output logic                 sv_valid_o,
    input  logic                 sv_ready_i,
    output logic [XLen-1:0]      sv_data_o,
    output logic                 sv_last_o,

    input  logic                 rs_valid_i,
    output logic                 rs_ready_o,
    input  logic [XLen-1:0]      rs_data_i,
    input  logic                 rs_last_i,

    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

`ifdef REGFILE_CTX_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        RESTORE,
        CHK,
        DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        RESTORE,
        DONE
    } state_e;
`endif

    localparam logic [NRegWidth-1:0] LastIdx = NRegWidth'(NReg - 1);

    state_e               state;
    logic [NRegWidth-1:0] idx;

`ifdef REGFILE_CTX_CHECKSUM_EN
    logic [XLen-1:0]      csum;
    // Set once the last data word has gone out; the next beat carries csum.
    logic                 csum_beat;
`endif

    // Stream and regfile-port steering; all zero in IDLE and DONE.
    always_comb begin
        cmd_ready_o = rst_ni && (state == IDLE);
        a1_o        = '0;
        a3_o        = '0;
        we3_o       = 1'b0;
        wd3_o       = '0;
        sv_valid_o  = 1'b0;
        sv_data_o   = '0;
        sv_last_o   = 1'b0;
        rs_ready_o  = 1'b0;
        case (state)
            SAVE: begin
                a1_o       = idx;
                sv_valid_o = 1'b1;
`ifdef REGFILE_CTX_CHECKSUM_EN
                sv_data_o  = csum_beat ? csum : rd1_i;
                sv_last_o  = csum_beat;
`else
                sv_data_o  = rd1_i;
                sv_last_o  = (idx == LastIdx);
`endif
            end
            RESTORE: begin
                rs_ready_o = 1'b1;
                we3_o      = rs_valid_i;
                a3_o       = idx;
                wd3_o      = rs_data_i;
            end
`ifdef REGFILE_CTX_CHECKSUM_EN
            CHK: begin
                rs_ready_o = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx       <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
`ifdef REGFILE_CTX_CHECKSUM_EN
            csum      <= '0;
            csum_beat <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        idx    <= NRegWidth'(1);
                        err_o  <= 1'b0;
                        busy_o <= 1'b1;
`ifdef REGFILE_CTX_CHECKSUM_EN
                        csum      <= '0;
                        csum_beat <= 1'b0;
`endif
                        state  <= cmd_op_i ? RESTORE : SAVE;
                    end
                end

                SAVE: begin
                    if (sv_ready_i) begin
`ifdef REGFILE_CTX_CHECKSUM_EN
                        if (csum_beat) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            csum <= csum ^ rd1_i;
                            // idx parks on the last index while the checksum beat is sent
                            if (idx == LastIdx) csum_beat <= 1'b1;
                            else                idx       <= idx + 1'b1;
                        end
`else
                        if (idx == LastIdx) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
`endif
                    end
                end

                RESTORE: begin
                    if (rs_valid_i) begin
`ifdef REGFILE_CTX_CHECKSUM_EN
                        csum <= csum ^ rs_data_i;
`endif
                        if (idx == LastIdx) begin
`ifdef REGFILE_CTX_CHECKSUM_EN
                            if (rs_last_i) begin
                                err_o  <= 1'b1;
                                state  <= DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= CHK;
                            end
`else
                            err_o  <= !rs_last_i;
                            state  <= DONE;
                            done_o <= 1'b1;
`endif
                        end else if (rs_last_i) begin
                            err_o  <= 1'b1;
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

`ifdef REGFILE_CTX_CHECKSUM_EN
                CHK: begin
                    if (rs_valid_i) begin
                        err_o  <= (rs_data_i != csum) || !rs_last_i;
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
`endif

                DONE: begin
                    idx    <= '0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_ctx_ctrl.sv
// Scoreboard bench for regfile_ctx_ctrl: random save/restore traffic against a behavioural regfile
// and stream reference; follows REGFILE_CTX_CHECKSUM_EN if it is defined for the build.
module tb_regfile_ctx_ctrl;
    localparam int NREG = 32;
    localparam int AW   = 5;
`ifdef REGFILE_CTX_CHECKSUM_EN
    localparam int LAST_POS = NREG;      // 31 data words + checksum word
`else
    localparam int LAST_POS = NREG - 1;  // 31 data words
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_op, cmd_ready;
    logic [AW-1:0] a1, a3;
    logic [31:0]   rd1, wd3;
    logic          we3;
    logic          sv_valid, sv_ready, sv_last;
    logic [31:0]   sv_data;
    logic          rs_valid, rs_ready, rs_last;
    logic [31:0]   rs_data;
    logic          busy, done, err;

    always #5 clk = ~clk;

    regfile_ctx_ctrl #(.XLen(32), .NReg(NREG), .NRegWidth(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_ready_o(cmd_ready),
        .a1_o(a1), .rd1_i(rd1), .a3_o(a3), .we3_o(we3), .wd3_o(wd3),
        .sv_valid_o(sv_valid), .sv_ready_i(sv_ready), .sv_data_o(sv_data), .sv_last_o(sv_last),
        .rs_valid_i(rs_valid), .rs_ready_o(rs_ready), .rs_data_i(rs_data), .rs_last_i(rs_last),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    // Environment regfile with a backdoor port for preloading
    logic [31:0]   mem [NREG];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;
    assign rd1 = mem[a1];
    always @(posedge clk) begin
        if (bd_we)    mem[bd_addr] <= bd_data;
        else if (we3) mem[a3] <= wd3;
    end

    // Reference state
    logic [31:0] exp_mem [NREG];
    logic [31:0] rwords  [NREG];
    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    beat_t sv_q[$];
    logic  done_q[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat or a done pulse
    logic  stall_prev = 1'b0;
    beat_t stall_beat;
    always @(negedge clk) begin
        beat_t b;
        #1;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("sv_valid_hold", {31'b0, sv_valid}, 32'd1);
                chk("sv_data_stable", sv_data, stall_beat.data);
                chk("sv_last_stable", {31'b0, sv_last}, {31'b0, stall_beat.last});
            end
            stall_prev = sv_valid && !sv_ready;
            stall_beat = '{data: sv_data, last: sv_last};
            if (sv_valid && sv_ready) begin
                if (sv_q.size() == 0) begin
                    total++;
                    $display("FAIL sv_unexpected_beat: got data %h, expected no beat", sv_data);
                end else begin
                    b = sv_q.pop_front();
                    chk("sv_data", sv_data, b.data);
                    chk("sv_last", {31'b0, sv_last}, {31'b0, b.last});
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++;
                    $display("FAIL done_unexpected: got done_o=1, expected 0");
                end else begin
                    chk("err_at_done", {31'b0, err}, {31'b0, done_q.pop_front()});
                end
            end
            if (we3) chk("we3_addr_nonzero", {31'b0, a3 != '0}, 32'd1);
        end
    end

    task automatic preload();
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            bd_we = 1'b1; bd_addr = AW'(i); bd_data = exp_mem[i];
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < NREG; i++)
            chk($sformatf("%s_x%0d", tag, i), mem[i], exp_mem[i]);
    endtask

    task automatic start_cmd(input logic op);
        @(negedge clk);
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        chk("err_cleared_on_accept", {31'b0, err}, 32'd0);
        chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
        if (op) chk("rs_ready_latency", {31'b0, rs_ready}, 32'd1);
        else    chk("sv_valid_latency", {31'b0, sv_valid}, 32'd1);
    endtask

    // mode 0: always ready, 1: ready toggles 1010..., 2: random ready
    task automatic do_save(input int mode);
        logic [31:0] x;
        int cyc;
        x = '0;
        for (int i = 1; i < NREG; i++) begin
            sv_q.push_back('{data: exp_mem[i], last: (LAST_POS == i)});
            x ^= exp_mem[i];
        end
`ifdef REGFILE_CTX_CHECKSUM_EN
        sv_q.push_back('{data: x, last: 1'b1});
`endif
        done_q.push_back(1'b0);
        start_cmd(1'b0);
        cyc = 0;
        while (1) begin
            case (mode)
                0:       sv_ready = 1'b1;
                1:       sv_ready = (cyc % 2 == 0);
                default: sv_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc > 400) begin
                total++;
                $display("FAIL save_timeout: got no done_o after %0d cycles, expected done", cyc);
                break;
            end
        end
        if (mode == 0) chk("save_done_cycle", cyc, LAST_POS);
        sv_ready = 1'b0;
        @(negedge clk);
        chk("busy_clear_after_save", {31'b0, busy}, 32'd0);
        chk("sv_q_drained", sv_q.size(), 32'd0);
    endtask

    // Sends stream positions 1..; position LAST_POS (with checksum) is csum_word.
    // last_at: position carrying rs_last (0 = never).
    task automatic do_restore(input int last_at, input logic [31:0] csum_word, input bit gaps);
        int stop, nwr, p, budget;
        logic exp_err, hs;
        logic [31:0] x;
        x = '0;
        for (int i = 1; i < NREG; i++) x ^= rwords[i];
        stop = (last_at == 0) ? LAST_POS : last_at;
        if (last_at == 0 || last_at < LAST_POS) exp_err = 1'b1;
        else begin
            exp_err = 1'b0;
`ifdef REGFILE_CTX_CHECKSUM_EN
            exp_err = (csum_word != x);
`endif
        end
        nwr = (stop > NREG - 1) ? NREG - 1 : stop;
        for (int i = 1; i <= nwr; i++) exp_mem[i] = rwords[i];
        done_q.push_back(exp_err);
        start_cmd(1'b1);
        p = 1; budget = 0;
        while (p <= stop) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                rs_valid = 1'b0; rs_data = $urandom; rs_last = 1'($urandom_range(0, 1));
            end else begin
                rs_valid = 1'b1;
                rs_data  = (p < NREG) ? rwords[p] : csum_word;
                rs_last  = (p == last_at);
            end
            hs = rs_valid && rs_ready;
            @(negedge clk);
            if (hs) p++;
            budget++;
            if (budget > 400) begin
                total++;
                $display("FAIL restore_timeout: got %0d words accepted, expected %0d", p - 1, stop);
                break;
            end
        end
        chk("restore_done_after_last", {31'b0, done}, 32'd1);
        rs_valid = 1'b0; rs_last = 1'b0;
        @(negedge clk);
        chk("busy_clear_after_restore", {31'b0, busy}, 32'd0);
        chk("err_holds_in_idle", {31'b0, err}, {31'b0, exp_err});
        check_mem("rf");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; sv_ready = 1'b0;
        rs_valid = 1'b1; rs_data = 32'h5A5A_A5A5; rs_last = 1'b0;
        #3;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_sv_valid", {31'b0, sv_valid}, 32'd0);
        chk("rst_rs_ready", {31'b0, rs_ready}, 32'd0);
        chk("rst_we3", {31'b0, we3}, 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("idle_a1", {27'b0, a1}, 32'd0);
        chk("idle_a3", {27'b0, a3}, 32'd0);
        chk("idle_wd3", wd3, 32'd0);
        chk("idle_we3", {31'b0, we3}, 32'd0);
        rs_valid = 1'b0;

        // Patterned save, continuous then stalled
        for (int i = 0; i < NREG; i++) exp_mem[i] = i * 32'h0101_0101;
        preload();
        do_save(0);
        do_save(1);
        // Random contents, random backpressure
        exp_mem[0] = '0;
        for (int i = 1; i < NREG; i++) exp_mem[i] = $urandom;
        preload();
        do_save(2);

        // Clean restore of 0xA0000001..0xA000001F
        x = '0;
        for (int i = 1; i < NREG; i++) begin
            rwords[i] = 32'hA000_0000 + i;
            x ^= rwords[i];
        end
        do_restore(LAST_POS, x, 1'b0);
        // Random words with valid gaps
        x = '0;
        for (int i = 1; i < NREG; i++) begin
            rwords[i] = $urandom;
            x ^= rwords[i];
        end
        do_restore(LAST_POS, x, 1'b1);
        // Early last on word 10, then at a random word
        for (int i = 1; i < NREG; i++) rwords[i] = 32'hB000_0000 + i;
        do_restore(10, 32'h0, 1'b0);
        do_save(0);
        for (int i = 1; i < NREG; i++) rwords[i] = $urandom;
        do_restore($urandom_range(1, 30), 32'h0, 1'b1);
        // Missing last
        x = '0;
        for (int i = 1; i < NREG; i++) begin
            rwords[i] = $urandom;
            x ^= rwords[i];
        end
        do_restore(0, x, 1'b0);
`ifdef REGFILE_CTX_CHECKSUM_EN
        x = '0;
        for (int i = 1; i < NREG; i++) begin
            rwords[i] = 32'hA000_0000 + i;
            x ^= rwords[i];
        end
        do_restore(LAST_POS, 32'hDEAD_BEEF, 1'b0);
        do_restore(LAST_POS, x, 1'b1);
        do_restore(NREG - 1, x, 1'b0);
`endif

        // Reset while word 5 of a restore is on the bus
        for (int i = 1; i < NREG; i++) rwords[i] = 32'hC000_0000 + i;
        for (int i = 1; i < 5; i++) exp_mem[i] = rwords[i];
        start_cmd(1'b1);
        for (int p = 1; p < 5; p++) begin
            rs_valid = 1'b1; rs_data = rwords[p]; rs_last = 1'b0;
            @(negedge clk);
        end
        rs_valid = 1'b1; rs_data = rwords[5]; rs_last = 1'b0;
        #1;
        chk("we3_before_reset", {31'b0, we3}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_we3_async", {31'b0, we3}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_rs_ready", {31'b0, rs_ready}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rs_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_reset_idle", {31'b0, cmd_ready}, 32'd1);
        check_mem("rf_after_reset");
        do_save(2);

        repeat (3) @(negedge clk);
        chk("done_q_drained", done_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
